// File: rtl/wb_commit_tracer_pkg.sv
// trace_pkg: commit record layout and shared constants for the write-back tracer.
// Records carry TRACE_SEQ_W sequence bits; narrower tracers zero-extend into the field.
package trace_pkg;
    localparam int TRACE_DEPTH = 16;
    localparam int TRACE_SEQ_W = 16;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [TRACE_SEQ_W-1:0] seq;
        logic [4:0]             dest;
        logic [31:0]            data;
    } commit_rec_t;
endpackage

// File: rtl/wb_commit_tracer_if.sv
// wb_commit_tracer_if: write-back tap, commit stream and shadow read port of the tracer.
interface wb_commit_tracer_if #(
    parameter int DEPTH  = 16,
    parameter int SEQ_W  = 16,
    parameter int DROP_W = 8
);
    logic                   wwreg;
    logic [4:0]             wdestReg;
    logic [31:0]            wbData;
    logic                   cm_ready;
    logic                   cm_valid;
    logic [SEQ_W-1:0]       cm_seq;
    logic [4:0]             cm_dest;
    logic [31:0]            cm_data;
    logic [$clog2(DEPTH):0] count;
    logic                   overflow;
    logic [DROP_W-1:0]      drop_cnt;
    logic [4:0]             shadow_addr;
    logic [31:0]            shadow_data;

    modport master (
        output wwreg, wdestReg, wbData, cm_ready, shadow_addr,
        input  cm_valid, cm_seq, cm_dest, cm_data, count, overflow, drop_cnt, shadow_data
    );

    modport slave (
        input  wwreg, wdestReg, wbData, cm_ready, shadow_addr,
        output cm_valid, cm_seq, cm_dest, cm_data, count, overflow, drop_cnt, shadow_data
    );
endinterface

// File: rtl/wb_commit_tracer_fifo.sv
// commit_fifo: synchronous show-ahead FIFO of commit records; a pop frees room for a
// push in the same cycle even when full.
module commit_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = TRACE_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  commit_rec_t            i_rec,
    input  logic                   i_pop,
    output commit_rec_t            o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);

    commit_rec_t r_mem [DEPTH];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [AW:0]   r_count;
    logic          w_pop;
    logic          w_push;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_head  = r_mem[r_rd];
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    // storage needs no reset: the pointers alone define which entries are live
    always_ff @(posedge clk) begin
        if (w_push && !rst) r_mem[r_wr] <= i_rec;
    end
endmodule

// File: rtl/wb_commit_tracer.sv
// wb_commit_tracer: passive write-back monitor logging register commits into a
// show-ahead FIFO with drop accounting, plus a shadow register file.
module wb_commit_tracer
    import trace_pkg::*;
#(
    parameter int DEPTH  = TRACE_DEPTH,
    parameter int SEQ_W  = TRACE_SEQ_W,
    parameter int DROP_W = 8
) (
    input logic              clk,
    input logic              rst,
    wb_commit_tracer_if.slave bus
);
    logic [SEQ_W-1:0]       r_seq;
    logic                   r_overflow;
    logic [DROP_W-1:0]      r_drop;
    logic [31:0]            r_shadow [32];
    logic                   w_commit;
    logic                   w_pop;
    logic                   w_drop;
    logic                   w_full;
    logic                   w_empty;
    logic [$clog2(DEPTH):0] w_count;
    commit_rec_t            w_rec;
    commit_rec_t            w_head;

    assign w_commit = bus.wwreg && (bus.wdestReg != REG_ZERO);
    assign w_pop    = bus.cm_ready && !w_empty;
    assign w_drop   = w_commit && w_full && !w_pop;
    assign w_rec    = '{seq: TRACE_SEQ_W'(r_seq), dest: bus.wdestReg, data: bus.wbData};

    commit_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_commit),
        .i_rec   (w_rec),
        .i_pop   (bus.cm_ready),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign bus.cm_valid    = !w_empty;
    assign bus.cm_seq      = w_head.seq[SEQ_W-1:0];
    assign bus.cm_dest     = w_head.dest;
    assign bus.cm_data     = w_head.data;
    assign bus.count       = w_count;
    assign bus.overflow    = r_overflow;
    assign bus.drop_cnt    = r_drop;
    assign bus.shadow_data = r_shadow[bus.shadow_addr];

    // entry 0 is never written by a commit, so it keeps its reset value of zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seq      <= '0;
            r_overflow <= 1'b0;
            r_drop     <= '0;
            for (int i = 0; i < 32; i++) r_shadow[i] <= '0;
        end else begin
            if (w_commit) begin
                r_seq                  <= r_seq + 1'b1;
                r_shadow[bus.wdestReg] <= bus.wbData;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop != '1) r_drop <= r_drop + 1'b1;
            end
        end
    end
endmodule
